// File: rtl/drp_arb_pkg.sv
// Shared types and constants for the DRP arbiter slice.
// Holds the FSM state encoding, the default timeout and the fill pattern used for timed-out reads.
package drp_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int TIMEOUT_DEFAULT = 1024;

  // Read data returned when the DRP port never answers; sliced to the data width at use.
  localparam logic [63:0] RSP_TMO_DATA = '1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/drp_arbiter_if.sv
// Requester-side and DRP-port-side bundles for the DRP arbiter.
// master drives the request or the DRP strobe; slave answers.
interface drp_req_if #(
  parameter int N_REQ = 2,
  parameter int AW    = 11,
  parameter int DW    = 32
);
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ-1:0][AW-1:0]  req_addr;
  logic [N_REQ-1:0][DW-1:0]  req_di;
  logic [N_REQ-1:0]          req_we;
  logic [N_REQ-1:0]          req_int;
  logic [N_REQ-1:0]          req_ready;
  logic [N_REQ-1:0]          rsp_valid;
  logic [DW-1:0]             rsp_do;
  logic                      rsp_timeout;

  modport master (
    output req_valid, req_addr, req_di, req_we, req_int,
    input  req_ready, rsp_valid, rsp_do, rsp_timeout
  );

  modport slave (
    input  req_valid, req_addr, req_di, req_we, req_int,
    output req_ready, rsp_valid, rsp_do, rsp_timeout
  );
endinterface

interface drp_port_if #(
  parameter int AW = 11,
  parameter int DW = 32
);
  logic [AW-1:0] drp_addr;
  logic [DW-1:0] drp_di;
  logic          drp_we;
  logic          drp_en;
  logic          drp_int_reg;
  logic [DW-1:0] drp_do;
  logic          drp_rdy;

  modport master (
    output drp_addr, drp_di, drp_we, drp_en, drp_int_reg,
    input  drp_do, drp_rdy
  );

  modport slave (
    input  drp_addr, drp_di, drp_we, drp_en, drp_int_reg,
    output drp_do, drp_rdy
  );
endinterface

// File: rtl/drp_rr_pick.sv
// Combinational round-robin pick: first set request searching upward from ptr+1, wrapping.
// Zero latency; no state, the caller owns the pointer.
module drp_rr_pick #(
  parameter int N_REQ = 2,
  parameter int IW    = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             any
);

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int off);
    return IW'((int'(p) + off) % N_REQ);
  endfunction

  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    // Offset N_REQ lands back on ptr itself, so the last owner is considered last.
    for (int i = 1; i <= N_REQ; i++) begin
      cand = wrap_idx(ptr, i);
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/drp_arbiter.sv
// Round-robin owner of the FPGA-level DRP port, one transaction in flight; request->drp_en 1 cycle,
// drp_rdy->rsp_valid 1 cycle, forced completion after TIMEOUT wait cycles; losers hold req_valid.
module drp_arbiter
  import drp_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int AW_FPGA = 11,
  parameter int DW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        drp_clk,
  input  logic        drp_rst_n,
  drp_req_if.slave    rq,
  drp_port_if.master  dp,
  output logic        busy,
  output logic [15:0] timeout_cnt
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [CW-1:0]      wcnt_q, wcnt_d;
  logic [AW_FPGA-1:0] addr_q, addr_d;
  logic [DW-1:0]      di_q, di_d;
  logic               we_q, we_d;
  logic               en_q, en_d;
  logic               int_reg_q, int_reg_d;
  logic [N_REQ-1:0]   ready_q, ready_d;
  logic [N_REQ-1:0]   rsp_vld_q, rsp_vld_d;
  logic [DW-1:0]      rsp_do_q, rsp_do_d;
  logic               rsp_tmo_q, rsp_tmo_d;
  logic               busy_q, busy_d;
  logic [15:0]        tcnt_q, tcnt_d;

  logic [N_REQ-1:0]   pick_oh;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  drp_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req   (rq.req_valid),
    .ptr   (ptr_q),
    .grant (pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Every port-facing output is a flop, so each one is computed one state ahead of where it is seen.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    wcnt_d    = wcnt_q;
    addr_d    = addr_q;
    di_d      = di_q;
    we_d      = we_q;
    en_d      = 1'b0;
    int_reg_d = 1'b0;
    ready_d   = '0;
    rsp_vld_d = '0;
    rsp_do_d  = rsp_do_q;
    rsp_tmo_d = rsp_tmo_q;
    tcnt_d    = tcnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          ptr_d     = pick_idx;
          grant_d   = pick_oh;
          addr_d    = rq.req_addr[pick_idx];
          di_d      = rq.req_di[pick_idx];
          we_d      = rq.req_we[pick_idx];
          en_d      = 1'b1;
          int_reg_d = rq.req_int[pick_idx];
          ready_d   = pick_oh;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wcnt_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A ready on the last allowed cycle still counts as a normal completion.
        if (dp.drp_rdy) begin
          rsp_do_d  = dp.drp_do;
          rsp_tmo_d = 1'b0;
          rsp_vld_d = grant_q;
          state_d   = ST_RESP;
        end else if (wcnt_q == WAIT_LAST) begin
          rsp_do_d  = RSP_TMO_DATA[DW-1:0];
          rsp_tmo_d = 1'b1;
          rsp_vld_d = grant_q;
          tcnt_d    = sat_inc16(tcnt_q);
          state_d   = ST_RESP;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge drp_clk or negedge drp_rst_n) begin
    if (!drp_rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= IW'(N_REQ - 1);
      grant_q   <= '0;
      wcnt_q    <= '0;
      addr_q    <= '0;
      di_q      <= '0;
      we_q      <= 1'b0;
      en_q      <= 1'b0;
      int_reg_q <= 1'b0;
      ready_q   <= '0;
      rsp_vld_q <= '0;
      rsp_do_q  <= '0;
      rsp_tmo_q <= 1'b0;
      busy_q    <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      wcnt_q    <= wcnt_d;
      addr_q    <= addr_d;
      di_q      <= di_d;
      we_q      <= we_d;
      en_q      <= en_d;
      int_reg_q <= int_reg_d;
      ready_q   <= ready_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_do_q  <= rsp_do_d;
      rsp_tmo_q <= rsp_tmo_d;
      busy_q    <= busy_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign rq.req_ready   = ready_q;
  assign rq.rsp_valid   = rsp_vld_q;
  assign rq.rsp_do      = rsp_do_q;
  assign rq.rsp_timeout = rsp_tmo_q;
  assign dp.drp_addr    = addr_q;
  assign dp.drp_di      = di_q;
  assign dp.drp_we      = we_q;
  assign dp.drp_en      = en_q;
  assign dp.drp_int_reg = int_reg_q;
  assign busy           = busy_q;
  assign timeout_cnt    = tcnt_q;

endmodule

// File: tb/tb_drp_arbiter.sv
// Directed plus randomized checks of drp_arbiter against a transaction-level model of grants,
// latencies and response data.
module tb_drp_arbiter;

  localparam int N   = 2;
  localparam int AW  = 11;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic        drp_clk   = 1'b0;
  logic        drp_rst_n = 1'b0;
  logic        busy;
  logic [15:0] timeout_cnt;

  drp_req_if  #(.N_REQ(N), .AW(AW), .DW(DW)) rq ();
  drp_port_if #(.AW(AW), .DW(DW))            dp ();

  drp_arbiter #(
    .N_REQ   (N),
    .AW_FPGA (AW),
    .DW      (DW),
    .TIMEOUT (TMO)
  ) dut (
    .drp_clk     (drp_clk),
    .drp_rst_n   (drp_rst_n),
    .rq          (rq),
    .dp          (dp),
    .busy        (busy),
    .timeout_cnt (timeout_cnt)
  );

  always #5 drp_clk = ~drp_clk;

  int nchk  = 0;
  int npass = 0;

  // Reference model state: requester intents and transaction-level expectations.
  logic [N-1:0]  pv;
  logic [AW-1:0] pa [N];
  logic [DW-1:0] pd [N];
  logic          pw [N];
  logic          pi [N];
  int            last_owner;
  logic [15:0]   exp_tcnt;
  logic [DW-1:0] exp_do;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge drp_clk);
    #1;
  endtask

  task automatic drive();
    rq.req_valid = pv;
    for (int r = 0; r < N; r++) begin
      rq.req_addr[r] = pa[r];
      rq.req_di[r]   = pd[r];
      rq.req_we[r]   = pw[r];
      rq.req_int[r]  = pi[r];
    end
  endtask

  task automatic post(input int r, input logic we, input logic in, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    pa[r] = a; pd[r] = d; pw[r] = we; pi[r] = in; pv[r] = 1'b1;
    drive();
  endtask

  function automatic int predict_grant();
    for (int i = 1; i <= N; i++) begin
      if (pv[(last_owner + i) % N]) return (last_owner + i) % N;
    end
    return 0;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "/ctl"}, {rq.req_ready, rq.rsp_valid, rq.rsp_timeout, dp.drp_we, dp.drp_en,
                        dp.drp_int_reg, busy}, 64'd0);
    chk({tag, "/rsp_do"}, rq.rsp_do, 64'd0);
    chk({tag, "/addr_di"}, {dp.drp_addr, dp.drp_di}, 64'd0);
    chk({tag, "/tcnt"}, timeout_cnt, 64'd0);
  endtask

  // One full transaction: d = cycles after drp_en that drp_rdy is raised (> TMO means never).
  task automatic serve(input int d, input logic [DW-1:0] dout, input logic rehold, input string tag);
    int            g, k, got, en_extra, exp_lat;
    logic [N-1:0]  oh;
    logic [AW-1:0] la;
    logic          exp_tmo;
    g = predict_grant();
    k = 0;
    do begin tick(); k++; end while (dp.drp_en !== 1'b1 && k < 8);
    chk({tag, "/en_lat"}, k, 1);
    oh = '0; oh[g] = 1'b1;
    chk({tag, "/grant"}, rq.req_ready, oh);
    chk({tag, "/addr"}, dp.drp_addr, pa[g]);
    chk({tag, "/di_we_int"}, {dp.drp_di, dp.drp_we, dp.drp_int_reg}, {pd[g], pw[g], pi[g]});
    chk({tag, "/busy"}, busy, 1);
    la = pa[g];
    last_owner = g;
    if (!rehold) pv[g] = 1'b0;
    pa[g] = AW'($urandom); pd[g] = $urandom;
    drive();
    got = -1; en_extra = 0;
    for (int j = 1; j <= TMO + 3; j++) begin
      tick();
      if (dp.drp_en) en_extra++;
      if (rq.rsp_valid != '0) begin got = j; break; end
      dp.drp_rdy = (j == d);
      dp.drp_do  = (j == d) ? dout : $urandom;
    end
    dp.drp_rdy = 1'b0;
    if (d >= 1 && d <= TMO) begin
      exp_lat = d + 1; exp_do = dout; exp_tmo = 1'b0;
    end else begin
      exp_lat = TMO + 1; exp_do = '1; exp_tmo = 1'b1;
      if (exp_tcnt != 16'hFFFF) exp_tcnt++;
    end
    chk({tag, "/rsp_lat"}, got, exp_lat);
    chk({tag, "/rsp_valid"}, rq.rsp_valid, oh);
    chk({tag, "/rsp_do"}, rq.rsp_do, exp_do);
    chk({tag, "/rsp_tmo"}, rq.rsp_timeout, exp_tmo);
    chk({tag, "/tcnt"}, timeout_cnt, exp_tcnt);
    chk({tag, "/single_en"}, en_extra, 0);
    chk({tag, "/addr_hold"}, dp.drp_addr, la);
    tick();
    chk({tag, "/rsp_pulse_busy"}, {rq.rsp_valid, busy}, 0);
  endtask

  task automatic stray_rdy(input string tag);
    dp.drp_rdy = 1'b1;
    dp.drp_do  = $urandom;
    tick();
    dp.drp_rdy = 1'b0;
    tick();
    chk({tag, "/no_rsp"}, rq.rsp_valid, 0);
    chk({tag, "/do_hold"}, rq.rsp_do, exp_do);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    pv = '0;
    for (int r = 0; r < N; r++) begin pa[r] = '0; pd[r] = '0; pw[r] = 1'b0; pi[r] = 1'b0; end
    drive();
    dp.drp_rdy = 1'b0;
    dp.drp_do  = '0;
    last_owner = N - 1;
    exp_tcnt   = '0;
    exp_do     = '0;

    // Reset state
    tick(); tick();
    check_all_zero("reset");
    drp_rst_n = 1'b1;
    tick();

    // Basic write and internal-register read
    post(0, 1'b1, 1'b0, 11'h205, 32'h1234_5678);
    serve(3, 32'h5555_0000, 1'b0, "t1_write");
    post(1, 1'b0, 1'b1, 11'h1A3, 32'h0BAD_0BAD);
    serve(2, 32'hCAFE_0001, 1'b0, "t2_read_int");

    // Both requesters held: alternation
    post(0, 1'b1, 1'b0, 11'h011, 32'h0000_1111);
    post(1, 1'b0, 1'b0, 11'h722, 32'h0000_2222);
    serve(1, 32'h1, 1'b1, "t3_a");
    serve(4, 32'h2, 1'b1, "t3_b");
    serve(2, 32'h3, 1'b1, "t3_c");
    pv[0] = 1'b0; drive();
    serve(5, 32'h4, 1'b0, "t3_d");

    // Timeout, then a late ready
    post(0, 1'b0, 1'b0, 11'h3FF, 32'h0);
    serve(TMO + 5, 32'h0, 1'b0, "t4_tmo");
    stray_rdy("t4_late");

    // Ready on the final wait cycle
    post(1, 1'b0, 1'b0, 11'h444, 32'h0);
    serve(TMO, 32'h0000_00A5, 1'b0, "t5_edge");

    // Reset during WAIT
    post(1, 1'b1, 1'b1, 11'h6AA, 32'h7777_8888);
    tick(); tick(); tick();
    drp_rst_n = 1'b0;
    #1;
    check_all_zero("t6_rst");
    pv = '0; drive();
    dp.drp_rdy = 1'b1; dp.drp_do = 32'hDEAD_BEEF;
    tick(); tick();
    dp.drp_rdy = 1'b0;
    drp_rst_n  = 1'b1;
    last_owner = N - 1; exp_tcnt = '0; exp_do = '0;
    tick();
    chk("t6_post_rst", {rq.rsp_valid, busy}, 0);
    post(1, 1'b0, 1'b0, 11'h101, 32'h0);
    post(0, 1'b1, 1'b0, 11'h202, 32'hABCD_0123);
    serve(3, 32'h600D_0000, 1'b0, "t6_first");
    serve(1, 32'h600D_0001, 1'b0, "t6_second");
    stray_rdy("t6_stray");

    // Randomized traffic
    for (int it = 0; it < 24; it++) begin
      int d;
      for (int r = 0; r < N; r++) begin
        if (!pv[r] && ($urandom_range(0, 1) == 1))
          post(r, 1'($urandom), 1'($urandom), AW'($urandom), $urandom);
      end
      if (pv == '0) post($urandom_range(0, N - 1), 1'($urandom), 1'($urandom), AW'($urandom), $urandom);
      d = ($urandom_range(0, 4) == 0) ? TMO + 5 : $urandom_range(1, TMO);
      serve(d, $urandom, 1'b0, $sformatf("rnd%0d", it));
    end
    while (pv != '0) serve($urandom_range(1, TMO), $urandom, 1'b0, "drain");

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
